// File: rtl/ob_cmd_arb.sv
// Multi-channel command ingress: per-channel FIFOs drained by an RR/fixed-priority arbiter into one registered output stage; push->out_vld_r is 2 cycles, 1 cmd/cycle sustained.
// Backpressure: cmd_full_r is registered per channel; a push into a full FIFO is dropped and latched in overflow_r until reset.
module ob_cmd_arb #(
    parameter int CH_N     = 4,
    parameter int W        = 64,
    parameter int DEPTH    = 4,
    parameter int ARB_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH_N-1:0]         cmd_vld_r,
    input  logic [CH_N*W-1:0]       cmd_r,
    output logic [CH_N-1:0]         cmd_full_r,
    input  logic [CH_N-1:0]         flush,
    input  logic                    out_pop,
    output logic                    out_vld_r,
    output logic [W-1:0]            out_r,
    output logic [$clog2(CH_N)-1:0] out_ch_r,
    output logic [CH_N-1:0]         overflow_r
);

    localparam int CW = $clog2(CH_N);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;

    logic [W-1:0]    mem_q    [CH_N][DEPTH];
    logic [W-1:0]    mem_d    [CH_N][DEPTH];
    logic [AW-1:0]   wr_ptr_q [CH_N];
    logic [AW-1:0]   wr_ptr_d [CH_N];
    logic [AW-1:0]   rd_ptr_q [CH_N];
    logic [AW-1:0]   rd_ptr_d [CH_N];
    logic [NW-1:0]   count_q  [CH_N];
    logic [NW-1:0]   count_d  [CH_N];
    logic [CH_N-1:0] full_q, full_d;
    logic [CH_N-1:0] ovf_q, ovf_d;

    logic            out_vld_q, out_vld_d;
    logic [W-1:0]    out_q, out_d;
    logic [CW-1:0]   out_ch_q, out_ch_d;
    logic [CW-1:0]   ptr_q, ptr_d;

    logic            load_en;
    logic [CH_N-1:0] req;
    logic            gnt_vld;
    logic [CW-1:0]   gnt;
    logic            found;
    logic [CW-1:0]   rr_idx [CH_N];
    logic [CH_N-1:0] push_ok;
    logic [CH_N-1:0] pop;

    // Round-robin search order: rr_idx[i] is the i-th candidate after ptr_q.
    always_comb begin
        for (int i = 0; i < CH_N; i++) begin
            rr_idx[i] = CW'((int'(ptr_q) + i) % CH_N);
        end
    end

    always_comb begin
        load_en = ~out_vld_q | out_pop;
        for (int c = 0; c < CH_N; c++) begin
            req[c] = (count_q[c] != '0) & ~flush[c];
        end
        gnt_vld = |req;
        gnt     = '0;
        found   = 1'b0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < CH_N; i++) begin
                if (!found && req[rr_idx[i]]) begin
                    found = 1'b1;
                    gnt   = rr_idx[i];
                end
            end
        end else begin
            for (int i = CH_N - 1; i >= 0; i--) begin
                if (req[i]) begin
                    gnt = CW'(i);
                end
            end
        end
    end

    // Full is computed from next_count, so a pop only frees a slot for the following cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        full_d   = full_q;
        ovf_d    = ovf_q;
        push_ok  = '0;
        pop      = '0;
        for (int c = 0; c < CH_N; c++) begin
            push_ok[c] = cmd_vld_r[c] & ~full_q[c] & ~flush[c];
            pop[c]     = load_en & gnt_vld & (gnt == CW'(c));
            ovf_d[c]   = ovf_q[c] | (cmd_vld_r[c] & full_q[c]);
            if (flush[c]) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                count_d[c]  = '0;
            end else begin
                if (push_ok[c]) begin
                    mem_d[c][wr_ptr_q[c]] = cmd_r[c*W +: W];
                    wr_ptr_d[c]           = wr_ptr_q[c] + AW'(1);
                end
                if (pop[c]) begin
                    rd_ptr_d[c] = rd_ptr_q[c] + AW'(1);
                end
                count_d[c] = count_q[c] + NW'(push_ok[c]) - NW'(pop[c]);
            end
            full_d[c] = (count_d[c] == NW'(DEPTH));
        end
    end

    always_comb begin
        out_vld_d = out_vld_q;
        out_d     = out_q;
        out_ch_d  = out_ch_q;
        ptr_d     = ptr_q;
        if (load_en) begin
            if (gnt_vld) begin
                out_vld_d = 1'b1;
                out_d     = mem_q[gnt][rd_ptr_q[gnt]];
                out_ch_d  = gnt;
                if (ARB_MODE == 0) begin
                    ptr_d = (gnt == CW'(CH_N - 1)) ? '0 : gnt + CW'(1);
                end
            end else begin
                out_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH_N; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
            full_q    <= '0;
            ovf_q     <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            out_ch_q  <= '0;
            ptr_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            out_ch_q  <= out_ch_d;
            ptr_q     <= ptr_d;
        end
    end

    // Storage needs no reset: entries are only read once count_q marks them valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign cmd_full_r = full_q;
    assign overflow_r = ovf_q;
    assign out_vld_r  = out_vld_q;
    assign out_r      = out_q;
    assign out_ch_r   = out_ch_q;

endmodule

// File: tb/tb_ob_cmd_arb.sv
// Bench for ob_cmd_arb: one round-robin and one fixed-priority instance share the stimulus;
// per-channel data queues plus an expected channel order form the scoreboard.
module tb_ob_cmd_arb;

    localparam int CH_N  = 4;
    localparam int W     = 64;
    localparam int DEPTH = 4;
    localparam int CW    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [CH_N-1:0]   cmd_vld_r = '0;
    logic [CH_N*W-1:0] cmd_r = '0;
    logic [CH_N-1:0]   flush = '0;
    logic              out_pop = 1'b0;

    logic [CH_N-1:0]   rr_full, rr_ovf, fp_full, fp_ovf;
    logic              rr_vld, fp_vld;
    logic [W-1:0]      rr_out, fp_out;
    logic [CW-1:0]     rr_ch, fp_ch;

    int                checks = 0;
    int                errors = 0;
    logic [W-1:0]      sb [CH_N][$];
    int                ch_exp [$];
    int                ec;
    logic [W-1:0]      ed;

    always #5 clk = ~clk;

    ob_cmd_arb #(.CH_N(CH_N), .W(W), .DEPTH(DEPTH), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst(rst), .cmd_vld_r(cmd_vld_r), .cmd_r(cmd_r), .cmd_full_r(rr_full),
        .flush(flush), .out_pop(out_pop), .out_vld_r(rr_vld), .out_r(rr_out),
        .out_ch_r(rr_ch), .overflow_r(rr_ovf)
    );

    ob_cmd_arb #(.CH_N(CH_N), .W(W), .DEPTH(DEPTH), .ARB_MODE(1)) u_fp (
        .clk(clk), .rst(rst), .cmd_vld_r(cmd_vld_r), .cmd_r(cmd_r), .cmd_full_r(fp_full),
        .flush(flush), .out_pop(out_pop), .out_vld_r(fp_vld), .out_r(fp_out),
        .out_ch_r(fp_ch), .overflow_r(fp_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_vld_r = '0;
        cmd_r     = '0;
        flush     = '0;
        out_pop   = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < CH_N; c++) sb[c].delete();
        ch_exp.delete();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rr_vld !== 1'b0 || fp_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_vld: got rr=%b fp=%b, expected 0", rr_vld, fp_vld);
        end
        checks++;
        if (rr_out !== '0 || rr_ch !== '0 || fp_out !== '0 || fp_ch !== '0) begin
            errors++;
            $display("FAIL reset_data: got rr %h/%0d fp %h/%0d, expected 0", rr_out, rr_ch, fp_out, fp_ch);
        end
        checks++;
        if (rr_full !== '0 || rr_ovf !== '0 || fp_full !== '0 || fp_ovf !== '0) begin
            errors++;
            $display("FAIL reset_flags: got full %b ovf %b, expected 0", rr_full, rr_ovf);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        out_pop      = 1'b1;
        cmd_vld_r[0] = 1'b1;
        cmd_r[0 +: W] = 64'h11;
        tick();
        cmd_vld_r = '0;
        checks++;
        if (rr_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_t1: got out_vld %b, expected 0", rr_vld);
        end
        tick();
        checks++;
        if (rr_vld !== 1'b1 || rr_out !== 64'h11 || rr_ch !== 2'd0) begin
            errors++;
            $display("FAIL single_t2: got vld %b data %h ch %0d, expected 1 11 0", rr_vld, rr_out, rr_ch);
        end
        tick();
        checks++;
        if (rr_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_t3: got out_vld %b, expected 0", rr_vld);
        end
    endtask

    task automatic test_rr();
        int order [12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 2, 0, 2};
        do_reset();
        out_pop = 1'b1;
        foreach (order[i]) ch_exp.push_back(order[i]);
        for (int cyc = 0; cyc < 20; cyc++) begin
            cmd_vld_r = '0;
            if (cyc == 0) begin
                for (int c = 0; c < CH_N; c++) begin
                    cmd_vld_r[c]    = 1'b1;
                    cmd_r[c*W +: W] = 64'h20 + 64'(c);
                    sb[c].push_back(64'h20 + 64'(c));
                end
            end else if (cyc <= 4) begin
                cmd_vld_r[0]    = 1'b1;
                cmd_r[0 +: W]   = 64'h100 + 64'(cyc);
                sb[0].push_back(64'h100 + 64'(cyc));
                cmd_vld_r[2]    = 1'b1;
                cmd_r[2*W +: W] = 64'h200 + 64'(cyc);
                sb[2].push_back(64'h200 + 64'(cyc));
            end
            if (rr_vld && out_pop) begin
                checks++;
                if (ch_exp.size() == 0) begin
                    errors++;
                    $display("FAIL rr_extra: got ch %0d data %h, expected no output", rr_ch, rr_out);
                end else begin
                    ec = ch_exp.pop_front();
                    ed = sb[ec].pop_front();
                    if (rr_ch !== CW'(ec) || rr_out !== ed) begin
                        errors++;
                        $display("FAIL rr_order: got ch %0d data %h, expected ch %0d data %h", rr_ch, rr_out, ec, ed);
                    end
                end
            end
            tick();
        end
        checks++;
        if (ch_exp.size() != 0 || rr_ovf !== '0) begin
            errors++;
            $display("FAIL rr_drain: got %0d outstanding ovf %b, expected 0 and 0000", ch_exp.size(), rr_ovf);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        cmd_vld_r[0]  = 1'b1;
        cmd_r[0 +: W] = 64'hA0;
        sb[0].push_back(64'hA0);
        ch_exp.push_back(0);
        tick();
        cmd_vld_r = '0;
        tick();
        checks++;
        if (rr_vld !== 1'b1) begin
            errors++;
            $display("FAIL ovf_stage: got out_vld %b, expected 1", rr_vld);
        end
        for (int i = 0; i < 5; i++) begin
            cmd_vld_r     = '0;
            cmd_vld_r[1]  = 1'b1;
            cmd_r[W +: W] = 64'h31 + 64'(i);
            if (i < 4) begin
                sb[1].push_back(64'h31 + 64'(i));
                ch_exp.push_back(1);
            end
            tick();
            checks++;
            if (rr_full[1] !== (i >= 3)) begin
                errors++;
                $display("FAIL ovf_full_%0d: got full %b, expected %b", i, rr_full[1], (i >= 3));
            end
            if (i == 3) begin
                checks++;
                if (rr_ovf !== '0) begin
                    errors++;
                    $display("FAIL ovf_early: got ovf %b, expected 0000", rr_ovf);
                end
            end
        end
        cmd_vld_r = '0;
        checks++;
        if (rr_ovf !== 4'b0010) begin
            errors++;
            $display("FAIL ovf_flag: got ovf %b, expected 0010", rr_ovf);
        end
        out_pop = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (rr_vld && out_pop) begin
                checks++;
                if (ch_exp.size() == 0) begin
                    errors++;
                    $display("FAIL ovf_extra: got ch %0d data %h, expected no output", rr_ch, rr_out);
                end else begin
                    ec = ch_exp.pop_front();
                    ed = sb[ec].pop_front();
                    if (rr_ch !== CW'(ec) || rr_out !== ed) begin
                        errors++;
                        $display("FAIL ovf_order: got ch %0d data %h, expected ch %0d data %h", rr_ch, rr_out, ec, ed);
                    end
                end
            end
            tick();
        end
        checks++;
        if (ch_exp.size() != 0 || rr_ovf !== 4'b0010) begin
            errors++;
            $display("FAIL ovf_drain: got %0d outstanding ovf %b, expected 0 and 0010", ch_exp.size(), rr_ovf);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cmd_vld_r       = '0;
            cmd_vld_r[2]    = 1'b1;
            cmd_r[2*W +: W] = 64'h40 + 64'(i);
            sb[2].push_back(64'h40 + 64'(i));
            ch_exp.push_back(2);
            tick();
        end
        cmd_vld_r = '0;
        checks++;
        if (rr_full[2] !== 1'b1 || rr_vld !== 1'b1) begin
            errors++;
            $display("FAIL fpp_setup: got full %b vld %b, expected 1 1", rr_full[2], rr_vld);
        end
        out_pop = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            cmd_vld_r = '0;
            if (cyc == 0) begin
                cmd_vld_r[2]    = 1'b1;
                cmd_r[2*W +: W] = 64'h4F;
            end else if (cyc == 1) begin
                checks++;
                if (rr_ovf[2] !== 1'b1 || rr_full[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL fpp_flags: got ovf %b full %b, expected 1 0", rr_ovf[2], rr_full[2]);
                end
                cmd_vld_r[2]    = 1'b1;
                cmd_r[2*W +: W] = 64'h50;
                sb[2].push_back(64'h50);
                ch_exp.push_back(2);
            end
            if (rr_vld && out_pop) begin
                checks++;
                if (ch_exp.size() == 0) begin
                    errors++;
                    $display("FAIL fpp_extra: got ch %0d data %h, expected no output", rr_ch, rr_out);
                end else begin
                    ec = ch_exp.pop_front();
                    ed = sb[ec].pop_front();
                    if (rr_ch !== CW'(ec) || rr_out !== ed) begin
                        errors++;
                        $display("FAIL fpp_order: got ch %0d data %h, expected ch %0d data %h", rr_ch, rr_out, ec, ed);
                    end
                end
            end
            tick();
        end
        checks++;
        if (ch_exp.size() != 0) begin
            errors++;
            $display("FAIL fpp_drain: got %0d outstanding, expected 0", ch_exp.size());
        end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cmd_vld_r       = 4'b1001;
            cmd_r[0 +: W]   = 64'h60 + 64'(i);
            cmd_r[3*W +: W] = 64'h70 + 64'(i);
            sb[0].push_back(64'h60 + 64'(i));
            sb[3].push_back(64'h70 + 64'(i));
            tick();
        end
        cmd_vld_r = '0;
        for (int i = 0; i < 3; i++) ch_exp.push_back(0);
        for (int i = 0; i < 3; i++) ch_exp.push_back(3);
        out_pop = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (fp_vld && out_pop) begin
                checks++;
                if (ch_exp.size() == 0) begin
                    errors++;
                    $display("FAIL fp_extra: got ch %0d data %h, expected no output", fp_ch, fp_out);
                end else begin
                    ec = ch_exp.pop_front();
                    ed = sb[ec].pop_front();
                    if (fp_ch !== CW'(ec) || fp_out !== ed) begin
                        errors++;
                        $display("FAIL fp_order: got ch %0d data %h, expected ch %0d data %h", fp_ch, fp_out, ec, ed);
                    end
                end
            end
            tick();
        end
        checks++;
        if (ch_exp.size() != 0) begin
            errors++;
            $display("FAIL fp_drain: got %0d outstanding, expected 0", ch_exp.size());
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cmd_vld_r     = 4'b0001;
            cmd_r[0 +: W] = 64'h80 + 64'(i);
            tick();
        end
        cmd_vld_r = '0;
        tick();
        flush[0] = 1'b1;
        tick();
        flush = '0;
        checks++;
        if (fp_vld !== 1'b1 || fp_out !== 64'h80 || fp_ch !== 2'd0) begin
            errors++;
            $display("FAIL flush_hold: got vld %b data %h ch %0d, expected 1 80 0", fp_vld, fp_out, fp_ch);
        end
        out_pop = 1'b1;
        tick();
        checks++;
        if (fp_vld !== 1'b0 || fp_full[0] !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: got vld %b full %b, expected 0 0", fp_vld, fp_full[0]);
        end
        tick();
        checks++;
        if (fp_vld !== 1'b0) begin
            errors++;
            $display("FAIL flush_stay: got vld %b data %h, expected 0", fp_vld, fp_out);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cmd_vld_r     = '0;
            cmd_vld_r[1]  = 1'b1;
            cmd_r[W +: W] = 64'h90 + 64'(i);
            if (i < 2) begin
                cmd_vld_r[3]    = 1'b1;
                cmd_r[3*W +: W] = 64'hB0 + 64'(i);
            end
            tick();
        end
        cmd_vld_r = '0;
        checks++;
        if (rr_vld !== 1'b1 || rr_ovf[1] !== 1'b1 || rr_full[1] !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: got vld %b ovf %b full %b, expected 1 1 1", rr_vld, rr_ovf[1], rr_full[1]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rr_vld !== 1'b0 || rr_out !== '0 || rr_ch !== '0) begin
            errors++;
            $display("FAIL mid_rst_out: got vld %b data %h ch %0d, expected 0", rr_vld, rr_out, rr_ch);
        end
        checks++;
        if (rr_full !== '0 || rr_ovf !== '0) begin
            errors++;
            $display("FAIL mid_rst_flags: got full %b ovf %b, expected 0", rr_full, rr_ovf);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < CH_N; c++) sb[c].delete();
        ch_exp.delete();
        sb[1].push_back(64'hC1);
        sb[3].push_back(64'hC3);
        ch_exp.push_back(1);
        ch_exp.push_back(3);
        out_pop = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            cmd_vld_r = '0;
            if (cyc == 0) begin
                cmd_vld_r       = 4'b1010;
                cmd_r[W +: W]   = 64'hC1;
                cmd_r[3*W +: W] = 64'hC3;
            end else if (cyc == 1) begin
                checks++;
                if (rr_vld !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_t1: got vld %b data %h, expected 0", rr_vld, rr_out);
                end
            end else if (cyc == 2) begin
                checks++;
                if (rr_vld !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_t2: got vld %b, expected 1", rr_vld);
                end
            end
            if (rr_vld && out_pop) begin
                checks++;
                if (ch_exp.size() == 0) begin
                    errors++;
                    $display("FAIL mid_extra: got ch %0d data %h, expected no output", rr_ch, rr_out);
                end else begin
                    ec = ch_exp.pop_front();
                    ed = sb[ec].pop_front();
                    if (rr_ch !== CW'(ec) || rr_out !== ed) begin
                        errors++;
                        $display("FAIL mid_order: got ch %0d data %h, expected ch %0d data %h", rr_ch, rr_out, ec, ed);
                    end
                end
            end
            tick();
        end
        checks++;
        if (ch_exp.size() != 0) begin
            errors++;
            $display("FAIL mid_drain: got %0d outstanding, expected 0", ch_exp.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_overflow();
        test_full_push_pop();
        test_fixed_prio();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
